pie_decoder: RTL and testbench
==============================

Name: pie_decoder

Overview:
- Recovers reader-to-tag commands from a sampled PIE waveform: delimiter, data-0, RTCAL, optional TRCAL, then data bits.
- Same-clock, single-bit input; sits on the tag-model/loopback path and checks the output of our PIE encoder.
- Measures symbols rising-edge to rising-edge and slices data bits against pivot = RTCAL/2.
- Emits one bit per symbol with a valid strobe, plus latched RTCAL/TRCAL lengths and frame/error pulses.

Parameters:
- DELIM_MIN, 3: minimum low-run length (cycles) that counts as a delimiter.
- MIN_SYM, 4: minimum legal symbol length (cycles, rising edge to rising edge).
- LEN_W, 6: width of the length counters; saturation and timeout value MAX_LEN = 2**LEN_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_pie  in  1  PIE waveform: idle/high, symbol = high then low pulse.
- out_bit  out  1  decoded data bit; meaningful only when out_valid=1.
- out_valid  out  1  one-cycle strobe per decoded data bit.
- frame_start  out  1  one-cycle pulse on delimiter detection.
- preamble_det  out  1  one-cycle pulse when TRCAL is measured.
- rtcal_len  out  LEN_W  last measured RTCAL, in cycles.
- trcal_len  out  LEN_W  last measured TRCAL, in cycles.
- error  out  1  one-cycle pulse on framing violation.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: in_q=1, low_cnt=0, sym_cnt=0, state=IDLE, rtcal_len=0, trcal_len=0. All outputs are 0.
- Edge detect:
  - in_q registers in_pie each cycle.
  - Rising edge E occurs in the cycle where in_pie=1 and in_q=0.
- low_cnt: increments (saturating) while in_pie=0; cleared when in_pie=1. At E it holds the preceding low-run length.
- sym_cnt: loads 1 on E, otherwise increments and saturates at MAX_LEN. At E, the symbol length L is the value of sym_cnt before the load, i.e. the number of cycles since the previous E.
- Output timing: all outputs are registered and asserted the cycle after E (or after the timeout cycle).
- Delimiter (highest priority, any state): E with low_cnt >= DELIM_MIN → pulse frame_start, go to SYNC0. In-progress frames restart.
- States and transitions, on E (non-delimiter):
  - IDLE: ignore edges.
  - SYNC0: L >= MIN_SYM → RTCAL; else error.
  - RTCAL: L >= MIN_SYM → latch rtcal_len=L, go to FIRST; else error.
  - FIRST: if L > rtcal_len, latch trcal_len=L, pulse preamble_det, go to DATA. Otherwise decode L as a data bit, go to DATA.
  - DATA: if MIN_SYM <= L <= rtcal_len, decode as a data bit and stay in DATA. Otherwise error.
- Data decode:
  - pivot = rtcal_len >> 1 (floor).
  - out_bit = (L >= pivot); exact equality decodes as 1.
  - Pulse out_valid.
- Error: pulse error, go to IDLE, no out_valid for the offending symbol. rtcal_len and trcal_len keep their last values.
- Timeout: sym_cnt reaches MAX_LEN with no E.
  - In SYNC0, RTCAL or FIRST → error, go to IDLE.
  - In DATA → go to IDLE silently (end of frame, no error).
- trcal_len changes only on a TRCAL measurement. A frame-sync without TRCAL leaves it unchanged.
- Simultaneous events: a delimiter edge always wins over symbol decode and the error checks for that edge.
- Reset mid-frame: next cycle all outputs are 0, state=IDLE, in_q=1; no pulses.
- Arithmetic: all comparisons are unsigned, LEN_W bits wide.

Test Plan:
- Preamble frame from encoder defaults (low 3, sync 6, RTCAL 16, TRCAL 32), bits 1,0,1,1 (lengths 10,6,10,10) → frame_start once; rtcal_len=16; trcal_len=32; preamble_det once; four out_valid with out_bit 1,0,1,1.
- Frame-sync (no TRCAL), bits 0,1 → rtcal_len=16, no preamble_det, trcal_len keeps previous value (32), out_bit 0,1.
- Pivot boundary with RTCAL=16: symbol L=8 → out_bit=1; L=7 → out_bit=0.
- Violations:
  - In DATA, symbol L=20 (> rtcal 16) → error pulse, busy=0, no out_valid.
  - Symbol L=3 in SYNC0 → error pulse.
- Delimiter mid-DATA (3 low cycles then E) → frame_start, state SYNC0, next sync/RTCAL accepted. rst asserted mid-frame → next cycle all outputs 0.
- Line held high 63 cycles in DATA → busy drops, no error. The same hold in RTCAL state → error pulse.

Source files
------------

// File: rtl/pie_decoder.sv
// PIE decoder: measures reader-to-tag symbols rising edge to rising edge,
// tracks delimiter / data-0 / RTCAL / TRCAL framing and slices data bits
// against pivot = RTCAL/2. All outputs are registered.
module pie_decoder #(
   parameter int unsigned DELIM_MIN = 3,
   parameter int unsigned MIN_SYM   = 4,
   parameter int unsigned LEN_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_pie,
   output logic             out_bit,
   output logic             out_valid,
   output logic             frame_start,
   output logic             preamble_det,
   output logic [LEN_W-1:0] rtcal_len,
   output logic [LEN_W-1:0] trcal_len,
   output logic             error,
   output logic             busy
);

   localparam logic [LEN_W-1:0] MaxLen   = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] DelimMin = LEN_W'(DELIM_MIN);
   localparam logic [LEN_W-1:0] MinSym   = LEN_W'(MIN_SYM);

   typedef enum logic [2:0] {StIdle, StSync0, StRtcal, StFirst, StData} state_e;

   state_e           state_q, state_d;
   logic             in_q;
   logic [LEN_W-1:0] low_cnt_q, low_cnt_d;
   logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [LEN_W-1:0] rtcal_d, trcal_d;
   logic             out_bit_d, out_valid_d, frame_start_d, preamble_d, error_d;

   logic             edge_det, delim, timeout, data_bit;
   logic [LEN_W-1:0] sym_len, pivot;

   assign edge_det = in_pie & ~in_q;
   // Symbol length is the counter value before the reload on this edge.
   assign sym_len  = sym_cnt_q;
   assign delim    = edge_det && (low_cnt_q >= DelimMin);
   assign timeout  = !edge_det && (sym_cnt_q == MaxLen);
   assign pivot    = rtcal_len >> 1;
   assign data_bit = (sym_len >= pivot);
   assign busy     = (state_q != StIdle);

   // Saturating low-run and symbol-length counters.
   always_comb begin
      low_cnt_d = low_cnt_q;
      sym_cnt_d = sym_cnt_q;
      if (in_pie) begin
         low_cnt_d = '0;
      end else if (low_cnt_q != MaxLen) begin
         low_cnt_d = low_cnt_q + 1'b1;
      end
      if (edge_det) begin
         sym_cnt_d = LEN_W'(1);
      end else if (sym_cnt_q != MaxLen) begin
         sym_cnt_d = sym_cnt_q + 1'b1;
      end
   end

   // Framing FSM next state and registered-output next values.
   always_comb begin
      state_d       = state_q;
      rtcal_d       = rtcal_len;
      trcal_d       = trcal_len;
      out_bit_d     = out_bit;
      out_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      preamble_d    = 1'b0;
      error_d       = 1'b0;
      if (delim) begin
         // Delimiter restarts framing from any state.
         frame_start_d = 1'b1;
         state_d       = StSync0;
      end else if (edge_det) begin
         case (state_q)
            StSync0: begin
               if (sym_len >= MinSym) begin
                  state_d = StRtcal;
               end else begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end
            end
            StRtcal: begin
               if (sym_len >= MinSym) begin
                  rtcal_d = sym_len;
                  state_d = StFirst;
               end else begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end
            end
            StFirst: begin
               // Anything longer than RTCAL here can only be TRCAL.
               if (sym_len > rtcal_len) begin
                  trcal_d    = sym_len;
                  preamble_d = 1'b1;
               end else begin
                  out_bit_d   = data_bit;
                  out_valid_d = 1'b1;
               end
               state_d = StData;
            end
            StData: begin
               if ((sym_len >= MinSym) && (sym_len <= rtcal_len)) begin
                  out_bit_d   = data_bit;
                  out_valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (timeout) begin
         // A stalled line mid-preamble is a violation; in DATA it ends the frame.
         case (state_q)
            StSync0, StRtcal, StFirst: begin
               error_d = 1'b1;
               state_d = StIdle;
            end
            StData:  state_d = StIdle;
            default: state_d = state_q;
         endcase
      end
   end

   // State, counters and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         in_q         <= 1'b1;
         low_cnt_q    <= '0;
         sym_cnt_q    <= '0;
         rtcal_len    <= '0;
         trcal_len    <= '0;
         out_bit      <= 1'b0;
         out_valid    <= 1'b0;
         frame_start  <= 1'b0;
         preamble_det <= 1'b0;
         error        <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_q         <= in_pie;
         low_cnt_q    <= low_cnt_d;
         sym_cnt_q    <= sym_cnt_d;
         rtcal_len    <= rtcal_d;
         trcal_len    <= trcal_d;
         out_bit      <= out_bit_d;
         out_valid    <= out_valid_d;
         frame_start  <= frame_start_d;
         preamble_det <= preamble_d;
         error        <= error_d;
      end
   end

endmodule

// File: tb/tb_pie_decoder.sv
// Bench for pie_decoder: directed frames plus random waveforms, every cycle
// compared against a timestamp-based reference model of the framing rules.
module tb_pie_decoder;

   localparam int DelimMin = 3;
   localparam int MinSym   = 4;
   localparam int MaxLen   = 63;

   localparam int MIdle  = 0;
   localparam int MSync0 = 1;
   localparam int MRtcal = 2;
   localparam int MFirst = 3;
   localparam int MData  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_pie = 1'b1;
   logic       out_bit, out_valid, frame_start, preamble_det, error, busy;
   logic [5:0] rtcal_len, trcal_len;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: edge timestamps instead of counters.
   int cyc = 0;
   int m_state, m_rtcal, m_trcal, m_last_high, m_last_edge;
   bit m_prev;
   bit m_valid, m_bit, m_fs, m_pre, m_err;

   // Observed activity collected for directed checks.
   bit got_bits[$];
   int fs_cnt, pre_cnt, err_cnt;

   pie_decoder #(
      .DELIM_MIN(3),
      .MIN_SYM  (4),
      .LEN_W    (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_pie      (in_pie),
      .out_bit     (out_bit),
      .out_valid   (out_valid),
      .frame_start (frame_start),
      .preamble_det(preamble_det),
      .rtcal_len   (rtcal_len),
      .trcal_len   (trcal_len),
      .error       (error),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic v, input logic b, input logic fs,
                                        input logic pre, input logic er, input logic bz,
                                        input logic [5:0] rt, input logic [5:0] tr);
      return {14'd0, v, v & b, fs, pre, er, bz, rt, tr};
   endfunction

   function automatic int sat(input int x);
      return (x > MaxLen) ? MaxLen : x;
   endfunction

   task automatic emit(input int len);
      m_valid = 1'b1;
      m_bit   = (len >= m_rtcal / 2);
   endtask

   // Predicts the outputs visible after the coming clock edge.
   task automatic model_step(input bit rst_v, input bit in_v);
      int  low_run, len;
      bit  rise, bad;
      m_valid = 0; m_bit = 0; m_fs = 0; m_pre = 0; m_err = 0;
      if (rst_v) begin
         m_state = MIdle; m_rtcal = 0; m_trcal = 0; m_prev = 1'b1;
         m_last_high = cyc; m_last_edge = cyc + 1;
      end else begin
         rise    = in_v && !m_prev;
         low_run = sat(cyc - m_last_high - 1);
         len     = sat(cyc - m_last_edge);
         bad     = 1'b0;
         if (rise) begin
            if (low_run >= DelimMin) begin
               m_fs = 1'b1;
               m_state = MSync0;
            end else begin
               case (m_state)
                  MSync0: if (len >= MinSym) m_state = MRtcal; else bad = 1'b1;
                  MRtcal: begin
                     if (len >= MinSym) begin
                        m_rtcal = len; m_state = MFirst;
                     end else bad = 1'b1;
                  end
                  MFirst: begin
                     if (len > m_rtcal) begin
                        m_trcal = len; m_pre = 1'b1;
                     end else emit(len);
                     m_state = MData;
                  end
                  MData: if (len >= MinSym && len <= m_rtcal) emit(len); else bad = 1'b1;
                  default: ;
               endcase
            end
            m_last_edge = cyc;
         end else if (len >= MaxLen) begin
            if (m_state == MSync0 || m_state == MRtcal || m_state == MFirst) bad = 1'b1;
            else if (m_state == MData) m_state = MIdle;
         end
         if (bad) begin
            m_err = 1'b1; m_state = MIdle;
         end
         if (in_v) m_last_high = cyc;
         m_prev = in_v;
      end
      cyc++;
   endtask

   task automatic step(input bit v);
      logic [31:0] o, e;
      in_pie = v;
      model_step(rst, v);
      @(posedge clk);
      #1;
      o = pack(out_valid, out_bit, frame_start, preamble_det, error, busy, rtcal_len, trcal_len);
      e = pack(m_valid, m_bit, m_fs, m_pre, m_err, m_state != MIdle, 6'(m_rtcal), 6'(m_trcal));
      check_eq("cycle", o, e);
      if (out_valid) got_bits.push_back(out_bit);
      if (frame_start) fs_cnt++;
      if (preamble_det) pre_cnt++;
      if (error) err_cnt++;
   endtask

   task automatic drive(input bit v, input int n);
      repeat (n) step(v);
   endtask

   // One symbol: high then a low pulse; its length is measured at the next rise.
   task automatic send_sym(input int len, input int pw);
      drive(1'b1, len - pw);
      drive(1'b0, pw);
   endtask

   task automatic clear_stats();
      got_bits.delete();
      fs_cnt = 0; pre_cnt = 0; err_cnt = 0;
   endtask

   function automatic int bits_value();
      int v = 0;
      foreach (got_bits[i]) v = v * 2 + int'(got_bits[i]);
      return v;
   endfunction

   task automatic rand_frame();
      int rt = $urandom_range(8, 30);
      int n  = $urandom_range(1, 8);
      int len;
      drive(1'b1, $urandom_range(1, 4));
      drive(1'b0, $urandom_range(3, 5));
      send_sym($urandom_range(3, 10), $urandom_range(1, 2));
      send_sym(rt, $urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1) send_sym($urandom_range(rt + 1, 60), 2);
      repeat (n) begin
         if ($urandom_range(0, 9) == 0) len = $urandom_range(2, 40);
         else len = $urandom_range(MinSym, rt);
         send_sym(len, (len > 2) ? $urandom_range(1, 2) : 1);
      end
      drive(1'b1, $urandom_range(1, 70));
   endtask

   initial begin
      rst = 1'b1;
      step(1'b1);
      check_eq("reset_outs", pack(out_valid, out_bit, frame_start, preamble_det, error, busy,
                                  rtcal_len, trcal_len), 32'd0);
      rst = 1'b0;
      drive(1'b1, 5);

      // Preamble frame with TRCAL, bits 1,0,1,1, then line held high in DATA.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(32, 2);
      send_sym(10, 2); send_sym(6, 2); send_sym(10, 2); send_sym(10, 2);
      drive(1'b1, 70);
      check_eq("pre_fs", fs_cnt, 1);
      check_eq("pre_det", pre_cnt, 1);
      check_eq("pre_rtcal", rtcal_len, 16);
      check_eq("pre_trcal", trcal_len, 32);
      check_eq("pre_nbits", got_bits.size(), 4);
      check_eq("pre_bits", bits_value(), 4'b1011);
      check_eq("data_hold_busy", busy, 0);
      check_eq("data_hold_err", err_cnt, 0);

      // Frame-sync without TRCAL keeps the old TRCAL.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(6, 2); send_sym(10, 2);
      drive(1'b1, 70);
      check_eq("fsync_pre", pre_cnt, 0);
      check_eq("fsync_trcal", trcal_len, 32);
      check_eq("fsync_rtcal", rtcal_len, 16);
      check_eq("fsync_bits", bits_value(), 2'b01);
      check_eq("fsync_nbits", got_bits.size(), 2);

      // Pivot boundary at RTCAL 16: 8 -> 1, 7 -> 0.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(8, 2); send_sym(7, 2);
      drive(1'b1, 70);
      check_eq("pivot_bits", bits_value(), 2'b10);
      check_eq("pivot_nbits", got_bits.size(), 2);

      // Over-long data symbol.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(10, 2); send_sym(20, 2);
      drive(1'b1, 5);
      check_eq("long_err", err_cnt, 1);
      check_eq("long_nbits", got_bits.size(), 1);
      check_eq("long_busy", busy, 0);
      drive(1'b1, 70);

      // Short sync symbol.
      clear_stats();
      drive(1'b0, 3);
      send_sym(3, 2);
      drive(1'b1, 5);
      check_eq("short_sync_err", err_cnt, 1);
      check_eq("short_sync_busy", busy, 0);
      drive(1'b1, 70);

      // Delimiter mid-DATA on an otherwise illegal length restarts the frame.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(10, 2);
      drive(1'b1, 20);
      drive(1'b0, 3);
      step(1'b1);
      check_eq("mid_delim_fs", frame_start, 1);
      check_eq("mid_delim_busy", busy, 1);
      drive(1'b1, 3);
      drive(1'b0, 2);
      send_sym(20, 2); send_sym(10, 2);
      drive(1'b1, 70);
      check_eq("mid_delim_fs_cnt", fs_cnt, 2);
      check_eq("mid_delim_err", err_cnt, 0);
      check_eq("mid_delim_rtcal", rtcal_len, 20);
      check_eq("mid_delim_bits", bits_value(), 2'b11);

      // Reset asserted mid-frame.
      drive(1'b0, 3);
      send_sym(6, 2); send_sym(16, 2); send_sym(32, 2);
      drive(1'b1, 3);
      rst = 1'b1;
      step(1'b1);
      rst = 1'b0;
      check_eq("rst_outs", pack(out_valid, out_bit, frame_start, preamble_det, error, busy,
                                rtcal_len, trcal_len), 32'd0);
      drive(1'b1, 70);

      // Line held high in RTCAL state is a violation.
      clear_stats();
      drive(1'b0, 3);
      send_sym(6, 2);
      drive(1'b1, 70);
      check_eq("rtcal_hold_err", err_cnt, 1);
      check_eq("rtcal_hold_busy", busy, 0);

      // Randomized frames and raw noise.
      for (int i = 0; i < 40; i++) rand_frame();
      for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)));
      for (int i = 0; i < 10; i++) rand_frame();
      drive(1'b1, 70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
